vga_cursor_overlay: RTL and testbench
=====================================

Name: vga_cursor_overlay

Overview:
Downstream pixel stage placed between the monochrome graphics mode and the DAC/pins. It consumes the graphics mode's RGB, sync and blank outputs. It overlays a 32x32 monochrome hardware cursor whose position, colour and bitmap are written over a Wishbone slave port. It re-emits timing-aligned RGB, sync and blank.

Parameters:
BPP, 8, bits per colour channel on input and output
SYNC_ACTIVE_LOW, 1, 1 = vs_i/hs_i asserted low (640x480 VGA), 0 = asserted high

Ports:
clk_i  in  1  pixel clock (25 MHz), same domain as upstream graphics mode
rst_i  in  1  asynchronous, active-low reset
vs_i  in  1  vertical sync from graphics mode
hs_i  in  1  horizontal sync from graphics mode
blank_n_i  in  1  active-video flag from graphics mode
red_i/green_i/blue_i  in  BPP each  upstream pixel colour
vs/hs  out  1  delayed syncs
blank_n  out  1  delayed active-video flag
red/green/blue  out  BPP each  overlaid pixel colour
bus  if_wb.slave  -  register/bitmap access port; 32-bit data, byte address

Behaviour:
- Reset (rst_i low, async): all pipeline registers 0; vs/hs driven deasserted per SYNC_ACTIVE_LOW; blank_n=0; RGB=0; all registers 0; bus.ack=0.
- Latency: exactly 2 clocks for every output relative to its input. Syncs, blank and RGB stay mutually aligned.
- Coordinate tracking (stage 1):
  - x (10b) increments each cycle blank_n_i=1; clears when blank_n_i=0.
  - y (9b) increments on blank_n_i falling edge; clears on vs_i assertion edge.
  - No wrap handling is needed beyond counter width.
- Register map (word offsets):
  - 0x00 CUR_X[9:0]
  - 0x04 CUR_Y[8:0]
  - 0x08 CTRL: bit0 enable, bit1 invert mode, bit2 blink (see feature)
  - 0x0C CUR_COLOR[3*BPP-1:0], packed {r,g,b}
  - 0x80-0xFC BITMAP rows 0-31; bit 31 = leftmost pixel.
  - Unmapped reads return 0; unmapped writes are ignored.
  - Unused register bits read 0.
- Wishbone handshake:
  - ack <= cyc & stb & !ack, giving a single-cycle ack one clock after the strobe.
  - Writes honour sel byte lanes.
  - Read data is valid in the ack cycle.
  - we=0 is a read. No stall and no err.
- Shadowing:
  - CUR_X, CUR_Y and CTRL are copied to shadow registers on each vs_i assertion edge. Mid-frame writes therefore take effect next frame.
  - BITMAP and CUR_COLOR apply immediately.
- Hit test (stage 1):
  - Condition: shadow enable, x >= sx, x < sx+32, y >= sy, y < sy+32, and blank_n_i=1.
  - Compute in 11/10-bit unsigned so sx near 639 clips without wrap.
  - Row = y-sy, col = x-sx. Bit = BITMAP[row][31-col].
- Output mux (stage 2):
  - If hit and bit=1:
    - invert mode → output ~input RGB;
    - otherwise → output CUR_COLOR.
  - Else pass the input through.
  - When blank_n=0, RGB=0 regardless.
- Simultaneous Wishbone write to CUR_X and a vs_i edge: the shadow captures the old value; the new value applies next frame.
- Reset mid-frame: output goes blank immediately. Counters resync at the next vs_i edge.

Optional Feature:
CURSOR_BLINK_EN:
- Defined:
  - 6-bit frame counter increments on each vs_i assertion edge.
  - With shadow CTRL bit2=1, the cursor is suppressed while counter[5]=1 (32 frames on, 32 off).
  - Counter resets to 0.
- Undefined:
  - No counter is built.
  - CTRL bit2 is unwritable and reads 0.
  - Cursor is always visible when enabled.

Decomposition:
- Shared package vga_pkg:
  - register offset constants (CUR_X_OFF, CUR_Y_OFF, CTRL_OFF, COLOR_OFF, BITMAP_BASE);
  - CTRL bit indices;
  - 640x480 active width/height constants;
  - cursor size constant 32.
- Sub-module vga_cursor_regs: Wishbone slave, register file, 32x32 bitmap storage and vs-edge shadowing. It exports the shadow values and a bitmap read port to the pipeline in the top module.

Test Plan:
- Reset release, then upstream blank_n_i=1, red_i=0x12 for 1 cycle → red=0x12 and blank_n=1 exactly 2 clocks later; vs/hs delayed by 2 identically.
- Read/write register file:
  - write CUR_COLOR=0x00FF00 with sel=4'hf → ack after 1 clock, single-cycle;
  - read back 0x00FF00;
  - read offset 0x40 → 0.
- Cursor draw:
  - CUR_X=100, CUR_Y=50, BITMAP[0]=0x80000001, CTRL=1, then a vs edge;
  - at line 50, pixel x=100 and x=131 → CUR_COLOR;
  - x=101 and x=132 → input colour.
- Invert mode: CTRL=3, input 0xA5A5A5 under a set bitmap bit → output 0x5A5A5A.
- Shadowing: write CUR_X=200 mid-frame → cursor stays at x=100 this frame and moves to 200 after the next vs edge.
- Clipping: CUR_X=630 → only columns 630-639 drawn, no wrap at x=0; with CURSOR_BLINK_EN and CTRL bit2=1, cursor visible frames 0-31 and absent frames 32-63.

Source files
------------

// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vga_pkg
//  Description : Shared constants for the VGA cursor overlay. Holds the
//                register map offsets, CTRL bit positions, active-area size,
//                cursor size, and a Wishbone byte-lane merge helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package vga_pkg;

    // Register map. These are byte offsets on the bus, word aligned.
    localparam logic [7:0] CUR_X_OFF   = 8'h00;
    localparam logic [7:0] CUR_Y_OFF   = 8'h04;
    localparam logic [7:0] CTRL_OFF    = 8'h08;
    localparam logic [7:0] COLOR_OFF   = 8'h0C;
    localparam logic [7:0] BITMAP_BASE = 8'h80;

    // CTRL bit positions
    localparam int CTRL_EN_BIT    = 0;
    localparam int CTRL_INV_BIT   = 1;
    localparam int CTRL_BLINK_BIT = 2;

    // Active area and the coordinate widths it implies
    localparam int H_ACTIVE    = 640;
    localparam int V_ACTIVE    = 480;
    localparam int X_W         = $clog2(H_ACTIVE);   // 10
    localparam int Y_W         = $clog2(V_ACTIVE);   // 9
    localparam int CURSOR_SIZE = 32;

    localparam int WB_AW = 8;

    // Replace each byte lane of old_word that is enabled in sel
    function automatic logic [31:0] wb_merge(input logic [31:0] old_word,
                                             input logic [31:0] wr_word,
                                             input logic [3:0]  sel);
        logic [31:0] merged;
        merged = old_word;
        for (int i = 0; i < 4; i++) begin
            if (sel[i]) merged[8*i +: 8] = wr_word[8*i +: 8];
        end
        return merged;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_cursor_overlay_if.sv
`default_nettype none
// ============================================================================
//  Module      : if_wb
//  Description : Classic single-cycle Wishbone bus carrying 32-bit data and
//                byte addresses. Masters drive cyc/stb/we/adr/sel/dat_w.
//                Slaves return dat_r/ack.
//  Revision    : 1.0 - initial release
// ============================================================================
interface if_wb #(
    parameter int AW = 8
);
    logic          cyc;
    logic          stb;
    logic          we;
    logic [AW-1:0] adr;
    logic [3:0]    sel;
    logic [31:0]   dat_w;
    logic [31:0]   dat_r;
    logic          ack;

    modport master (output cyc, stb, we, adr, sel, dat_w, input dat_r, ack);
    modport slave  (input cyc, stb, we, adr, sel, dat_w, output dat_r, ack);
endinterface
`default_nettype wire

// File: rtl/vga_cursor_regs.sv
`default_nettype none
// ============================================================================
//  Module      : vga_cursor_regs
//  Description : Wishbone register file for the cursor overlay. Holds
//                CUR_X, CUR_Y, CTRL, CUR_COLOR and the 32x32 bitmap.
//                Position and CTRL are copied to shadows on each vs edge.
//                Colour and bitmap are used live.
//  Config      : CURSOR_BLINK_EN - adds a 6-bit frame counter and makes
//                CTRL bit2 writable (blink).
//  Ports       : clk_i/rst_i    pixel clock, async active-low reset
//                bus            Wishbone slave
//                vs_edge_i      vs assertion edge from the pipeline
//                bmp_row_i/_o   bitmap read port for the pipeline
//                shd_*_o        shadowed position / invert mode
//                cursor_on_o    shadow enable with blink applied
//                color_o        live cursor colour {r,g,b}
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_cursor_regs
    import vga_pkg::*;
#(
    parameter int BPP = 8
) (
    input  wire logic             clk_i,
    input  wire logic             rst_i,
    if_wb.slave                   bus,
    input  wire logic             vs_edge_i,
    input  wire logic [4:0]       bmp_row_i,
    output logic      [31:0]      bmp_data_o,
    output logic      [X_W-1:0]   shd_x_o,
    output logic      [Y_W-1:0]   shd_y_o,
    output logic                  shd_inv_o,
    output logic                  cursor_on_o,
    output logic      [3*BPP-1:0] color_o
);

`ifdef CURSOR_BLINK_EN
    localparam logic [2:0] c_ctrl_mask = 3'b111;
`else
    localparam logic [2:0] c_ctrl_mask = 3'b011;
`endif

    logic [X_W-1:0]   cur_x_q, cur_x_d;
    logic [Y_W-1:0]   cur_y_q, cur_y_d;
    logic [2:0]       ctrl_q, ctrl_d;
    logic [3*BPP-1:0] color_q, color_d;
    logic [31:0]      bitmap_q [CURSOR_SIZE];
    logic [31:0]      bitmap_d [CURSOR_SIZE];
    logic [X_W-1:0]   shd_x_q, shd_x_d;
    logic [Y_W-1:0]   shd_y_q, shd_y_d;
    logic [2:0]       shd_ctrl_q, shd_ctrl_d;
    logic             ack_q, ack_d;
    logic [31:0]      rdat_q, rdat_d;

    logic        w_access;
    logic [7:0]  w_off;
    logic        w_is_bmp;
    logic [4:0]  w_row;
    logic [31:0] w_cur_word;
    logic [31:0] w_merged;
    logic        w_blink_off;
    logic        w_unused;

    // The low address bits are ignored because every register is word wide
    assign w_unused = ^{bus.adr[1:0], shd_ctrl_q[CTRL_BLINK_BIT]};

    // An ack holds off the next beat, so each strobe gets exactly one ack
    assign w_access = bus.cyc & bus.stb & ~ack_q;
    assign w_off    = {bus.adr[7:2], 2'b00};
    assign w_is_bmp = (w_off >= BITMAP_BASE);
    assign w_row    = bus.adr[6:2];

    // Current content of the addressed word. It serves as the read data and
    // as the base for byte-lane writes.
    always_comb begin
        w_cur_word = '0;
        if (w_is_bmp) begin
            w_cur_word = bitmap_q[w_row];
        end else begin
            case (w_off)
                CUR_X_OFF: w_cur_word = {{(32-X_W){1'b0}}, cur_x_q};
                CUR_Y_OFF: w_cur_word = {{(32-Y_W){1'b0}}, cur_y_q};
                CTRL_OFF:  w_cur_word = {29'd0, ctrl_q};
                COLOR_OFF: w_cur_word = {{(32-3*BPP){1'b0}}, color_q};
                default:   w_cur_word = '0;
            endcase
        end
    end

    assign w_merged = wb_merge(w_cur_word, bus.dat_w, bus.sel);

    always_comb begin
        cur_x_d    = cur_x_q;
        cur_y_d    = cur_y_q;
        ctrl_d     = ctrl_q;
        color_d    = color_q;
        bitmap_d   = bitmap_q;
        shd_x_d    = shd_x_q;
        shd_y_d    = shd_y_q;
        shd_ctrl_d = shd_ctrl_q;
        ack_d      = w_access;
        rdat_d     = '0;

        if (w_access && !bus.we) rdat_d = w_cur_word;

        if (w_access && bus.we) begin
            if (w_is_bmp) begin
                bitmap_d[w_row] = w_merged;
            end else begin
                case (w_off)
                    CUR_X_OFF: cur_x_d = w_merged[X_W-1:0];
                    CUR_Y_OFF: cur_y_d = w_merged[Y_W-1:0];
                    CTRL_OFF:  ctrl_d  = w_merged[2:0] & c_ctrl_mask;
                    COLOR_OFF: color_d = w_merged[3*BPP-1:0];
                    default:   ;
                endcase
            end
        end

        // Shadows sample the pre-write (_q) values. A write that lands on
        // the same edge as vs therefore takes effect one frame later.
        if (vs_edge_i) begin
            shd_x_d    = cur_x_q;
            shd_y_d    = cur_y_q;
            shd_ctrl_d = ctrl_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cur_x_q    <= '0;
            cur_y_q    <= '0;
            ctrl_q     <= '0;
            color_q    <= '0;
            shd_x_q    <= '0;
            shd_y_q    <= '0;
            shd_ctrl_q <= '0;
            ack_q      <= 1'b0;
            rdat_q     <= '0;
            for (int i = 0; i < CURSOR_SIZE; i++) bitmap_q[i] <= '0;
        end else begin
            cur_x_q    <= cur_x_d;
            cur_y_q    <= cur_y_d;
            ctrl_q     <= ctrl_d;
            color_q    <= color_d;
            shd_x_q    <= shd_x_d;
            shd_y_q    <= shd_y_d;
            shd_ctrl_q <= shd_ctrl_d;
            ack_q      <= ack_d;
            rdat_q     <= rdat_d;
            for (int i = 0; i < CURSOR_SIZE; i++) bitmap_q[i] <= bitmap_d[i];
        end
    end

`ifdef CURSOR_BLINK_EN
    logic [5:0] frame_cnt_q, frame_cnt_d;

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (vs_edge_i) frame_cnt_d = frame_cnt_q + 6'd1;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) frame_cnt_q <= '0;
        else        frame_cnt_q <= frame_cnt_d;
    end

    // The MSB splits the 64-frame period into 32 frames on, 32 frames off
    assign w_blink_off = shd_ctrl_q[CTRL_BLINK_BIT] & frame_cnt_q[5];
`else
    assign w_blink_off = 1'b0;
`endif

    assign bus.ack     = ack_q;
    assign bus.dat_r   = rdat_q;
    assign bmp_data_o  = bitmap_q[bmp_row_i];
    assign shd_x_o     = shd_x_q;
    assign shd_y_o     = shd_y_q;
    assign shd_inv_o   = shd_ctrl_q[CTRL_INV_BIT];
    assign cursor_on_o = shd_ctrl_q[CTRL_EN_BIT] & ~w_blink_off;
    assign color_o     = color_q;

endmodule
`default_nettype wire

// File: rtl/vga_cursor_overlay.sv
`default_nettype none
// ============================================================================
//  Module      : vga_cursor_overlay
//  Description : Two-stage pixel pipeline that overlays a 32x32 monochrome
//                hardware cursor on upstream RGB.
//                Stage 1 tracks x/y and runs the hit test.
//                Stage 2 muxes the output colour.
//                Sync, blank and RGB all leave exactly 2 clocks after entry.
//  Config      : CURSOR_BLINK_EN - blink support (see vga_cursor_regs)
//  Ports       : clk_i, rst_i (async active-low)
//                vs_i, hs_i, blank_n_i, red_i/green_i/blue_i   upstream
//                vs, hs, blank_n, red/green/blue               to DAC
//                bus                                           Wishbone slave
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_cursor_overlay
    import vga_pkg::*;
#(
    parameter int BPP             = 8,
    parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
    input  wire logic           clk_i,
    input  wire logic           rst_i,
    input  wire logic           vs_i,
    input  wire logic           hs_i,
    input  wire logic           blank_n_i,
    input  wire logic [BPP-1:0] red_i,
    input  wire logic [BPP-1:0] green_i,
    input  wire logic [BPP-1:0] blue_i,
    output logic                vs,
    output logic                hs,
    output logic                blank_n,
    output logic      [BPP-1:0] red,
    output logic      [BPP-1:0] green,
    output logic      [BPP-1:0] blue,
    if_wb.slave                 bus
);

    localparam logic       c_sync_idle = SYNC_ACTIVE_LOW ? 1'b1 : 1'b0;
    localparam logic [4:0] c_last_col  = 5'(CURSOR_SIZE - 1);

    logic [31:0]      w_bmp_data;
    logic [X_W-1:0]   w_shd_x;
    logic [Y_W-1:0]   w_shd_y;
    logic             w_shd_inv;
    logic             w_cursor_on;
    logic [3*BPP-1:0] w_color;

    logic             w_vs_act, w_vs_edge, w_blank_fall;
    logic             w_hit, w_pix;
    logic [4:0]       w_col, w_row;

    // Stage-1 state and tracking registers
    logic             vs_act_q, vs_act_d;
    logic             blank_prev_q, blank_prev_d;
    logic [X_W-1:0]   x_q, x_d;
    logic [Y_W-1:0]   y_q, y_d;
    logic             s1_vs_q, s1_vs_d;
    logic             s1_hs_q, s1_hs_d;
    logic             s1_blank_q, s1_blank_d;
    logic [3*BPP-1:0] s1_rgb_q, s1_rgb_d;
    logic             s1_draw_q, s1_draw_d;
    logic             s1_inv_q, s1_inv_d;

    // Stage-2 (output) registers
    logic             s2_vs_q, s2_vs_d;
    logic             s2_hs_q, s2_hs_d;
    logic             s2_blank_q, s2_blank_d;
    logic [3*BPP-1:0] s2_rgb_q, s2_rgb_d;

    vga_cursor_regs #(
        .BPP (BPP)
    ) u_regs (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .bus         (bus),
        .vs_edge_i   (w_vs_edge),
        .bmp_row_i   (w_row),
        .bmp_data_o  (w_bmp_data),
        .shd_x_o     (w_shd_x),
        .shd_y_o     (w_shd_y),
        .shd_inv_o   (w_shd_inv),
        .cursor_on_o (w_cursor_on),
        .color_o     (w_color)
    );

    assign w_vs_act     = SYNC_ACTIVE_LOW ? ~vs_i : vs_i;
    assign w_vs_edge    = w_vs_act & ~vs_act_q;
    assign w_blank_fall = blank_prev_q & ~blank_n_i;

    // Compare one bit wider than the coordinates so a cursor near the right
    // or bottom edge clips instead of wrapping back to column/row 0.
    always_comb begin
        w_hit = w_cursor_on && blank_n_i
             && ({1'b0, x_q} >= {1'b0, w_shd_x})
             && ({1'b0, x_q} <  ({1'b0, w_shd_x} + (X_W+1)'(CURSOR_SIZE)))
             && ({1'b0, y_q} >= {1'b0, w_shd_y})
             && ({1'b0, y_q} <  ({1'b0, w_shd_y} + (Y_W+1)'(CURSOR_SIZE)));
    end

    // Only the low 5 bits of the offsets matter inside the 32x32 window
    assign w_col = x_q[4:0] - w_shd_x[4:0];
    assign w_row = y_q[4:0] - w_shd_y[4:0];
    assign w_pix = w_bmp_data[c_last_col - w_col];   // bit 31 = leftmost

    always_comb begin
        vs_act_d     = w_vs_act;
        blank_prev_d = blank_n_i;
        x_d          = blank_n_i ? x_q + 1'b1 : '0;
        y_d          = y_q;
        if (w_vs_edge)         y_d = '0;
        else if (w_blank_fall) y_d = y_q + 1'b1;

        s1_vs_d    = vs_i;
        s1_hs_d    = hs_i;
        s1_blank_d = blank_n_i;
        s1_rgb_d   = {red_i, green_i, blue_i};
        s1_draw_d  = w_hit & w_pix;
        s1_inv_d   = w_shd_inv;

        s2_vs_d    = s1_vs_q;
        s2_hs_d    = s1_hs_q;
        s2_blank_d = s1_blank_q;
        s2_rgb_d   = s1_rgb_q;
        if (!s1_blank_q)    s2_rgb_d = '0;
        else if (s1_draw_q) s2_rgb_d = s1_inv_q ? ~s1_rgb_q : w_color;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            vs_act_q     <= 1'b0;
            blank_prev_q <= 1'b0;
            x_q          <= '0;
            y_q          <= '0;
            s1_vs_q      <= c_sync_idle;
            s1_hs_q      <= c_sync_idle;
            s1_blank_q   <= 1'b0;
            s1_rgb_q     <= '0;
            s1_draw_q    <= 1'b0;
            s1_inv_q     <= 1'b0;
            s2_vs_q      <= c_sync_idle;
            s2_hs_q      <= c_sync_idle;
            s2_blank_q   <= 1'b0;
            s2_rgb_q     <= '0;
        end else begin
            vs_act_q     <= vs_act_d;
            blank_prev_q <= blank_prev_d;
            x_q          <= x_d;
            y_q          <= y_d;
            s1_vs_q      <= s1_vs_d;
            s1_hs_q      <= s1_hs_d;
            s1_blank_q   <= s1_blank_d;
            s1_rgb_q     <= s1_rgb_d;
            s1_draw_q    <= s1_draw_d;
            s1_inv_q     <= s1_inv_d;
            s2_vs_q      <= s2_vs_d;
            s2_hs_q      <= s2_hs_d;
            s2_blank_q   <= s2_blank_d;
            s2_rgb_q     <= s2_rgb_d;
        end
    end

    assign vs      = s2_vs_q;
    assign hs      = s2_hs_q;
    assign blank_n = s2_blank_q;
    assign red     = s2_rgb_q[3*BPP-1:2*BPP];
    assign green   = s2_rgb_q[2*BPP-1:BPP];
    assign blue    = s2_rgb_q[BPP-1:0];

endmodule
`default_nettype wire

// File: tb/tb_vga_cursor_overlay.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vga_cursor_overlay
//  Description : Self-checking bench for vga_cursor_overlay. A reference
//                model computes the expected output for every driven pixel
//                and queues it. The entry is popped and compared when the
//                pixel reaches the DUT outputs. Register access is checked
//                against fixed values.
//  Config      : CURSOR_BLINK_EN - adds the blink sequence
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_cursor_overlay;
    import vga_pkg::*;

    localparam int BPP = 8;
    typedef logic [3*BPP+2:0] obs_t;   // {vs, hs, blank_n, rgb}

    logic clk = 1'b0;
    always #20 clk = ~clk;

    logic           rst_n;
    logic           vs_i, hs_i, blank_n_i;
    logic [BPP-1:0] red_i, green_i, blue_i;
    logic           vs, hs, blank_n;
    logic [BPP-1:0] red, green, blue;

    if_wb #(.AW(WB_AW)) bus_if ();

    vga_cursor_overlay #(
        .BPP             (BPP),
        .SYNC_ACTIVE_LOW (1'b1)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst_n),
        .vs_i      (vs_i),
        .hs_i      (hs_i),
        .blank_n_i (blank_n_i),
        .red_i     (red_i),
        .green_i   (green_i),
        .blue_i    (blue_i),
        .vs        (vs),
        .hs        (hs),
        .blank_n   (blank_n),
        .red       (red),
        .green     (green),
        .blue      (blue),
        .bus       (bus_if)
    );

    obs_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state: written registers, frame shadows, raster position
    logic [9:0]  m_cx, s_cx;
    logic [8:0]  m_cy, s_cy;
    logic [2:0]  m_ctrl, s_ctrl;
    logic [23:0] m_color;
    logic [31:0] m_bmp [32];
    int          mx, my, m_frames;
    bit          m_vs_prev, m_blank_prev;

`ifdef CURSOR_BLINK_EN
    localparam logic [2:0] CTRL_WR_MASK = 3'b111;
`else
    localparam logic [2:0] CTRL_WR_MASK = 3'b011;
`endif

    task automatic reset_model();
        m_cx = '0; s_cx = '0; m_cy = '0; s_cy = '0;
        m_ctrl = '0; s_ctrl = '0; m_color = '0;
        for (int i = 0; i < 32; i++) m_bmp[i] = '0;
        mx = 0; my = 0; m_frames = 0;
        m_vs_prev = 1'b0; m_blank_prev = 1'b0;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] model_rgb(input logic blank, input logic [23:0] in_rgb);
        bit on;
        int row, col;
        if (!blank) return 24'h0;
        on = s_ctrl[0];
`ifdef CURSOR_BLINK_EN
        if (s_ctrl[2] && ((m_frames % 64) >= 32)) on = 1'b0;
`endif
        if (on && mx >= int'(s_cx) && mx < int'(s_cx) + 32 &&
            my >= int'(s_cy) && my < int'(s_cy) + 32) begin
            row = my - int'(s_cy);
            col = mx - int'(s_cx);
            if (m_bmp[row][31-col]) return s_ctrl[1] ? ~in_rgb : m_color;
        end
        return in_rgb;
    endfunction

    // Drive one pixel clock: queue the expected output, advance the model,
    // clock, then compare the pixel that has just reached the outputs.
    task automatic tick();
        obs_t exp_v, got_v;
        bit   vs_act;
        exp_v = {vs_i, hs_i, blank_n_i, model_rgb(blank_n_i, {red_i, green_i, blue_i})};
        sb_q.push_back(exp_v);
        vs_act = ~vs_i;
        if (m_blank_prev && !blank_n_i) my++;
        if (vs_act && !m_vs_prev) begin
            my = 0; s_cx = m_cx; s_cy = m_cy; s_ctrl = m_ctrl; m_frames++;
        end
        mx = blank_n_i ? mx + 1 : 0;
        m_blank_prev = blank_n_i;
        m_vs_prev    = vs_act;
        @(posedge clk); #1;
        if (sb_q.size() >= 2) begin
            got_v = {vs, hs, blank_n, red, green, blue};
            exp_v = sb_q.pop_front();
            check($sformatf("pix x%0d y%0d", mx, my), 32'(got_v), 32'(exp_v));
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = s[i] ? n[8*i +: 8] : o[8*i +: 8];
        return r;
    endfunction

    task automatic model_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] t;
        if (a >= 8'h80) begin
            m_bmp[a[6:2]] = merge(m_bmp[a[6:2]], d, s);
        end else begin
            case (a)
                8'h00: begin t = merge({22'd0, m_cx}, d, s); m_cx = t[9:0]; end
                8'h04: begin t = merge({23'd0, m_cy}, d, s); m_cy = t[8:0]; end
                8'h08: begin t = merge({29'd0, m_ctrl}, d, s); m_ctrl = t[2:0] & CTRL_WR_MASK; end
                8'h0C: begin t = merge({8'd0, m_color}, d, s); m_color = t[23:0]; end
                default: ;
            endcase
        end
    endtask

    task automatic wb_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
        bus_if.cyc = 1'b1; bus_if.stb = 1'b1; bus_if.we = 1'b1;
        bus_if.adr = a; bus_if.sel = s; bus_if.dat_w = d;
        tick();
        check("wr_ack", 32'(bus_if.ack), 32'd1);
        bus_if.cyc = 1'b0; bus_if.stb = 1'b0; bus_if.we = 1'b0;
        model_write(a, d, s);
        tick();
        check("wr_ack_single", 32'(bus_if.ack), 32'd0);
    endtask

    task automatic wb_read(input logic [7:0] a, input logic [31:0] exp_d);
        bus_if.cyc = 1'b1; bus_if.stb = 1'b1; bus_if.we = 1'b0;
        bus_if.adr = a; bus_if.sel = 4'hf;
        tick();
        check("rd_ack", 32'(bus_if.ack), 32'd1);
        check($sformatf("rd_data@%h", a), bus_if.dat_r, exp_d);
        bus_if.cyc = 1'b0; bus_if.stb = 1'b0;
        tick();
        check("rd_ack_single", 32'(bus_if.ack), 32'd0);
    endtask

    task automatic idle(input int n);
        vs_i = 1'b1; hs_i = 1'b1; blank_n_i = 1'b0;
        for (int i = 0; i < n; i++) begin
            {red_i, green_i, blue_i} = 24'($urandom);
            tick();
        end
    endtask

    task automatic vs_pulse();
        blank_n_i = 1'b0; hs_i = 1'b1;
        vs_i = 1'b0; tick(); tick();
        vs_i = 1'b1; tick(); tick();
    endtask

    task automatic line(input int width, input bit fixed, input logic [23:0] rgb);
        vs_i = 1'b1; hs_i = 1'b1;
        for (int i = 0; i < width; i++) begin
            blank_n_i = 1'b1;
            {red_i, green_i, blue_i} = fixed ? rgb : 24'($urandom);
            tick();
        end
        blank_n_i = 1'b0;
        hs_i = 1'b0; tick(); tick();
        hs_i = 1'b1; tick(); tick();
    endtask

    // Lines 0..49 are short; line 50 carries the cursor rows under test
    task automatic frame_lines(input int width, input bit fixed, input logic [23:0] rgb);
        for (int l = 0; l < 50; l++) line(4, 1'b0, 24'h0);
        line(width, fixed, rgb);
        idle(2);
    endtask

    task automatic frame(input int width, input bit fixed, input logic [23:0] rgb);
        vs_pulse();
        frame_lines(width, fixed, rgb);
    endtask

    initial begin
        #50_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        vs_i = 1'b1; hs_i = 1'b1; blank_n_i = 1'b1;
        {red_i, green_i, blue_i} = 24'hABCDEF;
        bus_if.cyc = 1'b0; bus_if.stb = 1'b0; bus_if.we = 1'b0;
        bus_if.adr = '0; bus_if.sel = '0; bus_if.dat_w = '0;
        reset_model();
        repeat (3) @(posedge clk);
        #1;
        check("rst_out", 32'({vs, hs, blank_n, red, green, blue}), {5'd0, 3'b110, 24'h0});
        check("rst_ack", 32'(bus_if.ack), 32'd0);
        rst_n = 1'b1;
        idle(3);

        // One active pixel with both syncs asserted, then idle
        vs_i = 1'b0; hs_i = 1'b0; blank_n_i = 1'b1;
        {red_i, green_i, blue_i} = 24'h120000;
        tick();
        idle(1);
        check("lat2_red", 32'({vs, hs, blank_n, red}), {21'd0, 3'b001, 8'h12});
        idle(3);

        // Register file
        wb_write(COLOR_OFF, 32'h0000FF00, 4'hf);
        wb_read(COLOR_OFF, 32'h0000FF00);
        wb_read(8'h40, 32'h0);
        wb_write(8'h10, 32'hFFFFFFFF, 4'hf);
        wb_read(8'h10, 32'h0);
        wb_write(CUR_X_OFF, 32'd100, 4'hf);
        wb_write(CUR_X_OFF, 32'hFFFFFFFF, 4'b0001);
        wb_read(CUR_X_OFF, 32'h0FF);
        wb_write(CUR_X_OFF, 32'd100, 4'hf);
        wb_read(CUR_X_OFF, 32'd100);
        wb_write(CUR_Y_OFF, 32'hFFFF_FE32, 4'hf);
        wb_read(CUR_Y_OFF, 32'h032);
        wb_write(CTRL_OFF, 32'h7, 4'hf);
`ifdef CURSOR_BLINK_EN
        wb_read(CTRL_OFF, 32'h7);
`else
        wb_read(CTRL_OFF, 32'h3);
`endif
        wb_write(CTRL_OFF, 32'h1, 4'hf);
        wb_write(BITMAP_BASE, 32'h80000001, 4'hf);
        wb_read(BITMAP_BASE, 32'h80000001);

        // Cursor draw: columns 100 and 131 of line 50
        frame(140, 1'b0, 24'h0);

        // Invert mode
        wb_write(CTRL_OFF, 32'h3, 4'hf);
        frame(140, 1'b1, 24'hA5A5A5);

        // Mid-frame move: takes effect only after the next vs edge
        wb_write(CTRL_OFF, 32'h1, 4'hf);
        vs_pulse();
        wb_write(CUR_X_OFF, 32'd200, 4'hf);
        frame_lines(240, 1'b0, 24'h0);
        frame(240, 1'b0, 24'h0);

        // Write landing on the same edge as vs: shadow keeps the old value
        vs_i = 1'b0; blank_n_i = 1'b0; hs_i = 1'b1;
        wb_write(CUR_X_OFF, 32'd300, 4'hf);
        idle(2);
        frame_lines(340, 1'b0, 24'h0);
        frame(340, 1'b0, 24'h0);

        // Clipping at the right edge, no wrap to column 0
        wb_write(BITMAP_BASE, 32'hFFFFFFFF, 4'hf);
        wb_write(CUR_X_OFF, 32'd630, 4'hf);
        frame(640, 1'b0, 24'h0);

`ifdef CURSOR_BLINK_EN
        wb_write(CUR_X_OFF, 32'd0, 4'hf);
        wb_write(CUR_Y_OFF, 32'd0, 4'hf);
        wb_write(CTRL_OFF, 32'h5, 4'hf);
        for (int f = 0; f < 66; f++) begin
            vs_pulse();
            line(40, 1'b0, 24'h0);
            idle(1);
        end
`endif

        // Reset in the middle of an active line
        vs_i = 1'b1; hs_i = 1'b1; blank_n_i = 1'b1;
        {red_i, green_i, blue_i} = 24'h777777;
        tick(); tick(); tick();
        rst_n = 1'b0;
        #1;
        check("midrst_out", 32'({vs, hs, blank_n, red, green, blue}), {5'd0, 3'b110, 24'h0});
        sb_q.delete();
        reset_model();
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(2);
        wb_read(CUR_X_OFF, 32'h0);
        wb_read(COLOR_OFF, 32'h0);
        frame(140, 1'b0, 24'h0);
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
